// File: rtl/sound_frame_seq.sv
// rtl/sound_frame_seq.sv - APU timing source: 1 MHz divider tick and 512 Hz 8-step frame sequencer
// Strobes are registered and land on the same edge as the prescaler wrap that causes them.
module sound_frame_seq #(
  parameter int FREQ_DIV_RATIO = 4,
  parameter int FRAME_DIV      = 8192
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       sound_enable,
  output logic       clk_freq_div,
  output logic       clk_length_ctr,
  output logic       clk_sweep,
  output logic       clk_vol_env,
  output logic [2:0] frame_step
);

  localparam int DW = (FREQ_DIV_RATIO > 1) ? $clog2(FREQ_DIV_RATIO) : 1;
  localparam int FW = (FRAME_DIV > 1) ? $clog2(FRAME_DIV) : 1;
  localparam logic [DW-1:0] DIV_MAX = DW'(FREQ_DIV_RATIO - 1);
  localparam logic [FW-1:0] FRM_MAX = FW'(FRAME_DIV - 1);

  logic [DW-1:0] div_q, div_d;
  logic [FW-1:0] frm_q, frm_d;
  logic [2:0]    step_q, step_d;
  logic          fdiv_q, fdiv_d;
  logic          len_q, len_d;
  logic          sweep_q, sweep_d;
  logic          env_q, env_d;

  always_comb begin
    div_d   = div_q;
    frm_d   = frm_q;
    step_d  = step_q;
    fdiv_d  = 1'b0;
    len_d   = 1'b0;
    sweep_d = 1'b0;
    env_d   = 1'b0;
    if (!sound_enable) begin
      // Powered off: discard partial progress so the first tick after power-on is step 0.
      div_d  = '0;
      frm_d  = '0;
      step_d = 3'd7;
    end else begin
      if (div_q == DIV_MAX) begin
        div_d  = '0;
        fdiv_d = 1'b1;
      end else begin
        div_d = div_q + 1'b1;
      end
      if (frm_q == FRM_MAX) begin
        frm_d   = '0;
        step_d  = step_q + 3'd1;
        len_d   = ~step_d[0];
        sweep_d = (step_d == 3'd2) || (step_d == 3'd6);
        env_d   = (step_d == 3'd7);
      end else begin
        frm_d = frm_q + 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      div_q   <= '0;
      frm_q   <= '0;
      step_q  <= 3'd7;
      fdiv_q  <= 1'b0;
      len_q   <= 1'b0;
      sweep_q <= 1'b0;
      env_q   <= 1'b0;
    end else begin
      div_q   <= div_d;
      frm_q   <= frm_d;
      step_q  <= step_d;
      fdiv_q  <= fdiv_d;
      len_q   <= len_d;
      sweep_q <= sweep_d;
      env_q   <= env_d;
    end
  end

  assign clk_freq_div   = fdiv_q;
  assign clk_length_ctr = len_q;
  assign clk_sweep      = sweep_q;
  assign clk_vol_env    = env_q;
  assign frame_step     = step_q;

endmodule

// File: tb/tb_sound_frame_seq.sv
// tb/tb_sound_frame_seq.sv - self-checking bench for sound_frame_seq
// Reference: outputs derived from the count of consecutive enabled edges since reset/power-off.
module tb_sound_frame_seq;

  localparam int RATIO = 4;
  localparam int FDIV  = 16;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       sound_enable = 1'b0;
  logic       clk_freq_div, clk_length_ctr, clk_sweep, clk_vol_env;
  logic [2:0] frame_step;

  int n_cmp = 0;
  int n_bad = 0;
  int e = 0;

  sound_frame_seq #(.FREQ_DIV_RATIO(RATIO), .FRAME_DIV(FDIV)) dut (
    .clk            (clk),
    .rst            (rst),
    .sound_enable   (sound_enable),
    .clk_freq_div   (clk_freq_div),
    .clk_length_ctr (clk_length_ctr),
    .clk_sweep      (clk_sweep),
    .clk_vol_env    (clk_vol_env),
    .frame_step     (frame_step)
  );

  always #5 clk = ~clk;

  typedef struct {
    bit         r;
    bit         en;
    int         n;
    bit         fdiv;
    bit         len;
    bit         sw;
    bit         env;
    logic [2:0] step;
  } vec_t;

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s at edge-count %0d: got %0d want %0d", nm, e, act, exp);
    end
  endtask

  task automatic model_check();
    bit tick;
    int st;
    tick = (e > 0) && (e % FDIV == 0);
    st   = (e < FDIV) ? 7 : ((e / FDIV) - 1) % 8;
    check("freq_div", {31'd0, clk_freq_div}, ((e > 0) && (e % RATIO == 0)) ? 1 : 0);
    check("frame_step", {29'd0, frame_step}, st);
    check("length", {31'd0, clk_length_ctr}, (tick && (st % 2 == 0)) ? 1 : 0);
    check("sweep", {31'd0, clk_sweep}, (tick && (st == 2 || st == 6)) ? 1 : 0);
    check("envelope", {31'd0, clk_vol_env}, (tick && st == 7) ? 1 : 0);
  endtask

  task automatic cyc(input logic r, input logic en);
    rst = r;
    sound_enable = en;
    @(posedge clk);
    if (r || !en) e = 0;
    else e++;
    #1;
    model_check();
  endtask

  task automatic run(input logic r, input logic en, input int n);
    for (int i = 0; i < n; i++) cyc(r, en);
  endtask

  task automatic check_out(input string nm, input bit fdiv, input bit len, input bit sw,
                           input bit env, input logic [2:0] st);
    check({nm, ".freq_div"}, {31'd0, clk_freq_div}, {31'd0, fdiv});
    check({nm, ".length"}, {31'd0, clk_length_ctr}, {31'd0, len});
    check({nm, ".sweep"}, {31'd0, clk_sweep}, {31'd0, sw});
    check({nm, ".envelope"}, {31'd0, clk_vol_env}, {31'd0, env});
    check({nm, ".step"}, {29'd0, frame_step}, {29'd0, st});
  endtask

  vec_t vecs[11];

  initial begin
    vecs[0]  = '{1, 0, 3,   0, 0, 0, 0, 3'd7};
    vecs[1]  = '{0, 1, 3,   0, 0, 0, 0, 3'd7};
    vecs[2]  = '{0, 1, 1,   1, 0, 0, 0, 3'd7};
    vecs[3]  = '{0, 1, 11,  0, 0, 0, 0, 3'd7};
    vecs[4]  = '{0, 1, 1,   1, 1, 0, 0, 3'd0};
    vecs[5]  = '{0, 1, 1,   0, 0, 0, 0, 3'd0};
    vecs[6]  = '{0, 1, 15,  1, 0, 0, 0, 3'd1};
    vecs[7]  = '{0, 1, 16,  1, 1, 1, 0, 3'd2};
    vecs[8]  = '{0, 1, 80,  1, 0, 0, 1, 3'd7};
    vecs[9]  = '{0, 1, 16,  1, 1, 0, 0, 3'd0};
    vecs[10] = '{1, 1, 1,   0, 0, 0, 0, 3'd7};

    for (int i = 0; i < 11; i++) begin
      run(vecs[i].r, vecs[i].en, vecs[i].n);
      check_out($sformatf("vec%0d", i), vecs[i].fdiv, vecs[i].len, vecs[i].sw,
                vecs[i].env, vecs[i].step);
    end

    // Power-off exactly on a terminal-count edge (edge 32).
    run(1, 0, 2);
    run(0, 1, 31);
    cyc(0, 0);
    check_out("off_terminal", 0, 0, 0, 0, 3'd7);
    run(0, 0, 5);
    check_out("off_hold", 0, 0, 0, 0, 3'd7);
    run(0, 1, 15);
    check_out("reon_pre", 0, 0, 0, 0, 3'd7);
    cyc(0, 1);
    check_out("reon_tick", 1, 1, 0, 0, 3'd0);

    // Disable mid-prescaler at frame count 9; partial progress must be lost.
    run(1, 0, 2);
    run(0, 1, 9);
    cyc(0, 0);
    run(0, 1, 3);
    check_out("mid_div3", 0, 0, 0, 0, 3'd7);
    cyc(0, 1);
    check_out("mid_div4", 1, 0, 0, 0, 3'd7);
    run(0, 1, 3);
    check_out("mid_edge7", 0, 0, 0, 0, 3'd7);
    run(0, 1, 9);
    check_out("mid_edge16", 1, 1, 0, 0, 3'd0);

    // Reset while enabled at step 3.
    run(1, 0, 2);
    run(0, 1, 69);
    check_out("at_step3", 0, 0, 0, 0, 3'd3);
    cyc(1, 1);
    check_out("rst_ovr", 0, 0, 0, 0, 3'd7);
    run(0, 1, 16);
    check_out("rst_restart", 1, 1, 0, 0, 3'd0);

    // Randomized enable/reset traffic against the reference model.
    for (int i = 0; i < 4000; i++) begin
      cyc(($urandom_range(0, 199) == 0) ? 1'b1 : 1'b0,
          ($urandom_range(0, 99) < 98) ? 1'b1 : 1'b0);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/sound_frame_seq.md
# sound_frame_seq

Timing source for the APU sound channels. Divides the CPU clock into a 1048576 Hz divider tick and a 512 Hz frame sequencer. The frame sequencer steps through 8 phases and emits the 256 Hz length, 128 Hz sweep and 64 Hz volume-envelope strobes that drive every channel's `clk_freq_div`, `clk_length_ctr`, `clk_sweep` and `clk_vol_env` inputs. Sits directly upstream of the square, wave and noise channel blocks. Gated by the master sound enable (NR52 bit 7).

## Interface
- `FREQ_DIV_RATIO`, default 4: CPU clocks per `clk_freq_div` pulse (4194304 / 1048576); must be ≥2.
- `FRAME_DIV`, default 8192: CPU clocks per frame-sequencer step (4194304 / 512); must be ≥2.
- `clk` in, 1: CPU clock; all logic on its rising edge.
- `rst` in, 1: synchronous reset, active-high.
- `sound_enable` in, 1: master sound power (NR52 bit 7); 0 means powered off.
- `clk_freq_div` out, 1: one-cycle pulse every `FREQ_DIV_RATIO` clocks.
- `clk_length_ctr` out, 1: one-cycle pulse on frame steps 0, 2, 4, 6.
- `clk_sweep` out, 1: one-cycle pulse on frame steps 2, 6.
- `clk_vol_env` out, 1: one-cycle pulse on frame step 7.
- `frame_step` out, 3: current frame-sequencer step.

## Operation
- Reset values: `clk_freq_div`, `clk_length_ctr`, `clk_sweep` and `clk_vol_env` are 0. `frame_step` is 7. Both prescaler counters are 0.
- Divider prescaler
  - Width is ceil(log2(`FREQ_DIV_RATIO`)).
  - Counts 0..`FREQ_DIV_RATIO`-1 on each enabled edge.
  - On the edge where it wraps to 0, `clk_freq_div` registers 1 for exactly one cycle. Otherwise it registers 0.
- Frame prescaler
  - Width is ceil(log2(`FRAME_DIV`)).
  - Counts 0..`FRAME_DIV`-1 and is independent of the divider prescaler.
  - On the edge where it wraps to 0, `frame_step` increments modulo 8 (7→0). On the same edge, the strobes register their decode of the new step value:
    - length = new step even;
    - sweep = new step ∈ {2, 6};
    - envelope = new step == 7.
  - On all other edges the strobes register 0.
- Step sequence:
  - Step 0: length.
  - Step 1: none.
  - Step 2: length + sweep.
  - Step 3: none.
  - Step 4: length.
  - Step 5: none.
  - Step 6: length + sweep.
  - Step 7: envelope.
- Power off (`sound_enable`=0, sampled each edge)
  - Both prescalers are cleared to 0.
  - `frame_step` is forced to 7.
  - All strobe outputs register 0.
  - No pulse may be emitted on the edge where `sound_enable` is sampled low, even if that edge is a terminal count.
- Power on
  - Counting resumes from 0 on the first edge with `sound_enable`=1.
  - The first frame tick therefore lands on step 0 and produces a length strobe. This is required so that channel length counters restart in phase after NR52 is written.
- Priority: `rst` > `sound_enable`=0 > normal counting.
- Strobes are glitch-free registered outputs. Consumers treat each rising edge as exactly one event.

## Timing
- Edge numbering: edge 1 is the first rising `clk` edge with `rst`=0 and `sound_enable`=1.
- `clk_freq_div`: high after edges k·`FREQ_DIV_RATIO` (k≥1), low after every other edge. Period is exactly `FREQ_DIV_RATIO` with a 1-cycle high time.
- Frame tick n (n≥1): occurs at edge n·`FRAME_DIV`.
  - `frame_step` becomes (n−1) mod 8 after that edge.
  - The matching strobes are high for the single following cycle.
- Latency from a frame tick to the strobes is 0 additional cycles: the strobes and `frame_step` update on the same edge.
- When ticks coincide, `clk_length_ctr` and `clk_sweep` are high in the same cycle. `clk_vol_env` never coincides with either.
- Reset mid-step: on the `rst` edge all state returns to reset values. Counting restarts as if power-on.
- Disable mid-step: partial prescaler progress is discarded. It is never carried over to the next enable.

## Test plan
Run with `FRAME_DIV`=16 and `FREQ_DIV_RATIO`=4 unless noted.
- **Reset then enable.** Hold `rst` for 3 cycles, then set `sound_enable`=1.
  - `frame_step` reads 7 until edge 16. After edge 16 it reads 0, with `clk_length_ctr`=1 for one cycle and `clk_sweep`=`clk_vol_env`=0.
  - `clk_freq_div` is high after edges 4, 8, 12, 16.
- **Full sequence over 8 ticks (128 cycles).**
  - Length pulses at steps 0, 2, 4, 6.
  - Sweep pulses at steps 2, 6.
  - Envelope pulse at step 7 only.
  - Step 8 wraps to 0 and emits a length pulse.
- **Defaults.** With 4194304 clocks at `FRAME_DIV`=8192: 512 frame ticks, 256 length pulses, 128 sweep pulses, 64 envelope pulses, and 1048576 `clk_freq_div` pulses.
- **Power-off on terminal edge.** Drop `sound_enable` on edge 32.
  - No strobe is emitted on that edge.
  - `frame_step` goes to 7 and all outputs stay 0 while disabled.
  - After re-enable, the next tick is 16 edges later, at step 0.
- **Disable mid-prescaler.** Disable at frame count 9, re-enable.
  - The first tick occurs 16 edges after re-enable, not 7.
  - The first `clk_freq_div` pulse occurs 4 edges after re-enable.
- **Reset overrides enable.** Assert `rst` while `sound_enable`=1 at step 3.
  - All outputs are 0 and `frame_step`=7 on the next cycle.
  - Sequencing then restarts exactly as in the first scenario.
